thinning_stream: RTL and testbench

THINNING_STREAM -- requirements
Module: thinning_stream

---
 rtl/thinning_stream.sv | 166 ++++++++++++++++
 tb/tb_thinning_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/thinning_stream.sv
// Streaming Zhang-Suen thinning sub-iteration over a binary raster frame.
// A delay chain spanning two image lines plus the 3x3 window feeds a registered output stage.
module thinning_stream #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_sel,
   input  logic             in_pixel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] changed_count
);

   localparam int COL_W  = $clog2(IMG_WIDTH);
   localparam int ROW_W  = $clog2(IMG_HEIGHT);
   localparam int HIST_W = 2*IMG_WIDTH+3;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH-1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT-1);

   typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

   state_t state, stateNext;

   logic [HIST_W-1:0] hist, histNext;
   logic [COL_W-1:0]  inCol, outCol;
   logic [ROW_W-1:0]  inRow, outRow;
   logic              stepReg, allOut, outDel;
   logic              transfer, outFree, acceptIn, produce, startOk;
   logic              lastIn, fillDone, lastOut;
   logic              northOk, southOk, westOk, eastOk;
   logic              p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic [7:0]        nb;
   logic [3:0]        bCount, aCount;
   logic              stepOk, del;

   assign transfer = out_valid & out_ready;
   assign outFree  = ~out_valid | out_ready;
   assign in_ready = (state == FILL) | ((state == RUN) & outFree);
   assign acceptIn = in_ready & in_valid;
   assign produce  = ((state == RUN) & acceptIn) | ((state == FLUSH) & ~allOut & outFree);
   assign startOk  = (state == IDLE) & start;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   assign lastIn   = (inRow == LAST_ROW) & (inCol == LAST_COL);
   assign fillDone = (inRow == ROW_W'(1)) & (inCol == '0);
   assign lastOut  = (outRow == LAST_ROW) & (outCol == LAST_COL);

   // Newest sample sits at bit 0; the centre pixel is IMG_WIDTH+1 samples behind it.
   assign histNext = {hist[HIST_W-2:0], acceptIn ? in_pixel : 1'b0};

   assign northOk = (outRow != '0);
   assign southOk = (outRow != LAST_ROW);
   assign westOk  = (outCol != '0);
   assign eastOk  = (outCol != LAST_COL);

   assign p1 = histNext[IMG_WIDTH+1];
   assign p2 = histNext[2*IMG_WIDTH+1] & northOk;
   assign p3 = histNext[2*IMG_WIDTH]   & northOk & eastOk;
   assign p4 = histNext[IMG_WIDTH]     & eastOk;
   assign p5 = histNext[0]             & southOk & eastOk;
   assign p6 = histNext[1]             & southOk;
   assign p7 = histNext[2]             & southOk & westOk;
   assign p8 = histNext[IMG_WIDTH+2]   & westOk;
   assign p9 = histNext[2*IMG_WIDTH+2] & northOk & westOk;

   // Neighbour count B, clockwise 0->1 transition count A, and the deletion decision.
   always_comb begin
      nb     = {p9, p8, p7, p6, p5, p4, p3, p2};
      bCount = '0;
      aCount = '0;
      for (int i = 0; i < 8; i++) begin
         bCount = bCount + {3'b000, nb[i]};
         aCount = aCount + {3'b000, ~nb[i] & nb[(i+1)%8]};
      end
      if (stepReg)
         stepOk = ~(p2 & p4 & p8) & ~(p2 & p6 & p8);
      else
         stepOk = ~(p2 & p4 & p6) & ~(p4 & p6 & p8);
      del = p1 & (bCount >= 4'd2) & (bCount <= 4'd6) & (aCount == 4'd1) & stepOk;
   end

   // Frame sequencing state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // Next-state logic: the FLUSH phase ends only once the final output has been taken.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = FILL;
         FILL:    if (acceptIn && fillDone) stateNext = RUN;
         RUN:     if (acceptIn && lastIn) stateNext = FLUSH;
         FLUSH:   if (transfer && allOut) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Datapath: delay chain, raster counters, output register and deletion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist          <= '0;
         inCol         <= '0;
         inRow         <= '0;
         outCol        <= '0;
         outRow        <= '0;
         stepReg       <= 1'b0;
         allOut        <= 1'b0;
         outDel        <= 1'b0;
         out_valid     <= 1'b0;
         out_pixel     <= 1'b0;
         changed_count <= '0;
      end else if (startOk) begin
         stepReg       <= step_sel;
         changed_count <= '0;
         allOut        <= 1'b0;
         inCol         <= '0;
         inRow         <= '0;
         outCol        <= '0;
         outRow        <= '0;
      end else begin
         if (acceptIn || produce)
            hist <= histNext;
         if (acceptIn) begin
            if (inCol == LAST_COL) begin
               inCol <= '0;
               inRow <= (inRow == LAST_ROW) ? '0 : inRow + 1'b1;
            end else begin
               inCol <= inCol + 1'b1;
            end
         end
         if (produce) begin
            if (outCol == LAST_COL) begin
               outCol <= '0;
               outRow <= (outRow == LAST_ROW) ? '0 : outRow + 1'b1;
            end else begin
               outCol <= outCol + 1'b1;
            end
            if (lastOut)
               allOut <= 1'b1;
            out_valid <= 1'b1;
            out_pixel <= p1 & ~del;
            outDel    <= del;
         end else if (transfer) begin
            out_valid <= 1'b0;
         end
         if (transfer && outDel)
            changed_count <= changed_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_thinning_stream.sv
// Self-checking bench for thinning_stream: a 4x4 and an 8x6 instance driven in turn,
// compared against a direct neighbourhood model of the thinning rule.
module tb_thinning_stream;

   logic clk = 1'b0;
   logic rst, start, stepSel, inPix, inValid, outReady, useBig;

   logic ir4, ov4, op4, b4, fd4;
   logic ir8, ov8, op8, b8, fd8;
   logic [4:0] cc4;
   logic [5:0] cc8;

   logic inReady, outValid, outPix, busy, frameDone;
   logic [31:0] changedCount;

   int img[48];
   int expOut[48];
   int got[48];
   int w, h, n, expDel;
   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   thinning_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start & ~useBig), .step_sel(stepSel),
      .in_pixel(inPix), .in_valid(inValid), .in_ready(ir4),
      .out_pixel(op4), .out_valid(ov4), .out_ready(outReady),
      .busy(b4), .frame_done(fd4), .changed_count(cc4)
   );

   thinning_stream #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) dut8 (
      .clk(clk), .rst(rst), .start(start & useBig), .step_sel(stepSel),
      .in_pixel(inPix), .in_valid(inValid), .in_ready(ir8),
      .out_pixel(op8), .out_valid(ov8), .out_ready(outReady),
      .busy(b8), .frame_done(fd8), .changed_count(cc8)
   );

   assign inReady      = useBig ? ir8 : ir4;
   assign outValid     = useBig ? ov8 : ov4;
   assign outPix       = useBig ? op8 : op4;
   assign busy         = useBig ? b8  : b4;
   assign frameDone    = useBig ? fd8 : fd4;
   assign changedCount = useBig ? {26'd0, cc8} : {27'd0, cc4};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int px(int r, int c);
      if (r < 0 || r >= h || c < 0 || c >= w) return 0;
      return img[r*w + c];
   endfunction

   // Reference: evaluate every pixel from its eight neighbours directly in the image.
   function automatic void buildModel(int step);
      int nbv[8];
      int b, a;
      bit cond, del;
      expDel = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            nbv[0] = px(r-1, c);   nbv[1] = px(r-1, c+1);
            nbv[2] = px(r, c+1);   nbv[3] = px(r+1, c+1);
            nbv[4] = px(r+1, c);   nbv[5] = px(r+1, c-1);
            nbv[6] = px(r, c-1);   nbv[7] = px(r-1, c-1);
            b = 0;
            a = 0;
            for (int i = 0; i < 8; i++) begin
               b += nbv[i];
               if (nbv[i] == 0 && nbv[(i+1)%8] == 1) a++;
            end
            if (step == 0)
               cond = !(nbv[0] && nbv[2] && nbv[4]) && !(nbv[2] && nbv[4] && nbv[6]);
            else
               cond = !(nbv[0] && nbv[2] && nbv[6]) && !(nbv[0] && nbv[4] && nbv[6]);
            del = (px(r, c) == 1) && b >= 2 && b <= 6 && a == 1 && cond;
            expOut[r*w + c] = del ? 0 : px(r, c);
            if (del) expDel++;
         end
      end
   endfunction

   task automatic selectDut(input bit big);
      useBig = big;
      w = big ? 8 : 4;
      h = big ? 6 : 4;
      n = w * h;
   endtask

   task automatic clearImage();
      for (int i = 0; i < 48; i++) img[i] = 0;
   endtask

   task automatic randomImage();
      for (int i = 0; i < 48; i++) img[i] = int'($urandom_range(0, 1));
   endtask

   task automatic startFrame(input int stepS);
      @(negedge clk);
      inValid = 1'b0;
      start   = 1'b1;
      stepSel = (stepS != 0);
      @(negedge clk);
      start   = 1'b0;
      stepSel = (stepS == 0);
      #1;
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("countCleared", changedCount, 0);
   endtask

   // Runs one frame; optional output stall, stray start pulse, or early return for an abort.
   task automatic applyStimulus(input int stepS, input int stallAt, input int stallLen,
                                input int pulseAt, input int abortAt);
      int inIdx = 0, outIdx = 0, doneCnt = 0, postDone = 0, stallSeen = 0;
      logic prevHold = 1'b0, prevPix = 1'b0;
      buildModel(stepS);
      startFrame(stepS);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         outReady = !(cyc >= stallAt && cyc < stallAt + stallLen);
         inValid  = (inIdx < n) && ($urandom_range(0, 3) != 0);
         inPix    = (inIdx < n) ? img[inIdx][0] : 1'b0;
         start    = (cyc == pulseAt);
         #1;
         if (prevHold) begin
            checkOutput("holdValid", outValid, 1);
            checkOutput("holdPixel", outPix, prevPix);
         end
         if (outValid && !outReady) begin
            stallSeen++;
            checkOutput("stallInReady", inReady, 0);
         end
         prevHold = outValid && !outReady;
         prevPix  = outPix;
         if (outValid && outReady) begin
            if (outIdx < 48) got[outIdx] = outPix;
            outIdx++;
         end
         if (inValid && inReady) inIdx++;
         if (frameDone) doneCnt++;
         if (abortAt >= 0 && inIdx == abortAt) begin
            start = 1'b0;
            return;
         end
         if (doneCnt > 0) postDone++;
         if (postDone == 4) break;
      end
      start    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      checkOutput("outCount", outIdx, n);
      checkOutput("doneCount", doneCnt, 1);
      checkOutput("changedCount", changedCount, expDel);
      checkOutput("busyIdle", busy, 0);
      checkOutput("readyIdle", inReady, 0);
      if (stallLen > 0) checkOutput("stallSeen", stallSeen > 0, 1);
      for (int i = 0; i < n && i < outIdx && i < 48; i++)
         checkOutput($sformatf("pix%0d", i), got[i], expOut[i][0]);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_outValid"}, outValid, 0);
      checkOutput({tag, "_outPix"}, outPix, 0);
      checkOutput({tag, "_inReady"}, inReady, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, frameDone, 0);
      checkOutput({tag, "_count"}, changedCount, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; stepSel = 1'b0; inPix = 1'b0;
      inValid = 1'b0; outReady = 1'b1; useBig = 1'b0;
      selectDut(0);
      repeat (3) @(negedge clk);
      #1;
      checkResetState("reset4");
      selectDut(1);
      #1;
      checkResetState("reset8");
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;

      $display("[TB] 4x4 all-zero frame");
      selectDut(0);
      clearImage();
      applyStimulus(0, -1, 0, -1, -1);

      $display("[TB] 4x4 isolated pixel");
      clearImage();
      img[5] = 1;
      applyStimulus(0, -1, 0, -1, -1);

      $display("[TB] 4x4 corner block, both sub-iterations");
      clearImage();
      img[0] = 1; img[1] = 1; img[2] = 1;
      img[5] = 1; img[6] = 1;
      img[9] = 1; img[10] = 1;
      applyStimulus(0, -1, 0, -1, -1);
      checkOutput("block_step1_p11", got[5], 1);
      applyStimulus(1, -1, 0, -1, -1);
      checkOutput("block_step2_p11", got[5], 0);

      $display("[TB] 8x6 random frames");
      selectDut(1);
      randomImage();
      applyStimulus(0, -1, 0, -1, -1);
      applyStimulus(0, 25, 5, -1, -1);
      randomImage();
      applyStimulus(1, 20, 5, 30, -1);

      $display("[TB] 8x6 reset mid-frame");
      randomImage();
      applyStimulus(1, -1, 0, -1, 10);
      @(negedge clk);
      rst     = 1'b1;
      inValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abort_outValid", outValid, 0);
      checkOutput("abort_inReady", inReady, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_count", changedCount, 0);
      applyStimulus(1, -1, 0, -1, -1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
